cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares one common data bus (CDB) among three result producers: ALU, load/store buffer (LSB) and reorder buffer (ROB).
- Each producer pushes {tag, value} into its own small FIFO. Producers therefore never collide.
- A round-robin scheduler pops one entry per cycle and drives it onto the registered CDB. The reservation station, LSB and ROB snoop this bus instead of three separate broadcast ports.
- A mispredict flush discards all buffered results.

Parameters:
- DATA_W, 32, result value width.
- TAG_W, 4, ROB index (rename tag) width.
- DEPTH, 4, entries per source FIFO; power of two, at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- rdy  input  1  global ready; when low, all state holds
- flush  input  1  jump_wrong; discards all pending results
- alu_valid  input  1  ALU result present this cycle
- alu_tag  input  TAG_W  ROB index of ALU result
- alu_value  input  DATA_W  ALU result value
- alu_full  output  1  ALU FIFO cannot accept a push
- lsb_valid / lsb_tag / lsb_value / lsb_full: same as ALU, for the LSB source
- rob_valid / rob_tag / rob_value / rob_full: same as ALU, for the ROB source
- cdb_valid  output  1  broadcast valid (registered)
- cdb_tag  output  TAG_W  broadcast ROB index (registered)
- cdb_value  output  DATA_W  broadcast value (registered)
- cdb_src  output  2  source granted: 0 = ALU, 1 = LSB, 2 = ROB (registered)

Behaviour:
- Priority at each posedge: rst, then flush, then (rdy high) normal operation, else hold all state.
- Reset:
  - all FIFOs empty (head, tail and count = 0);
  - cdb_valid, cdb_tag, cdb_value, cdb_src = 0;
  - last_grant = 2, so ALU has first priority.
- FIFO per source:
  - count range 0..DEPTH, stored in clog2(DEPTH)+1 bits;
  - head/tail are clog2(DEPTH)-bit pointers that wrap modulo DEPTH.
- Full flag: src_full = (count == DEPTH) | ~rdy. It is combinational and has no look-ahead for a same-cycle pop.
- Push: accepted at a posedge when src_valid & ~src_full & ~flush & ~rst. A push offered while full is dropped. Producers must honour src_full.
- Pop: at most one pop per cycle across all sources.
  - Candidates are the FIFOs whose count is nonzero before the edge. An entry pushed at edge E is poppable at edge E+1 at the earliest.
  - Search order after last_grant = g: (g+1)%3, (g+2)%3, g.
  - The first non-empty source wins, and last_grant takes its index.
  - last_grant is unchanged when nothing is granted.
- Push and pop on the same FIFO in one cycle: both happen and count is unchanged. This is legal at count = DEPTH-1 and at count = 1.
- CDB outputs on a grant: cdb_valid = 1; cdb_tag, cdb_value and cdb_src come from the winner's head entry.
- CDB outputs with no grant: cdb_valid = 0; tag, value and src hold their previous values.
- Latency: data sampled at edge E appears on the CDB after edge E+1 at best. Worst case is 3*DEPTH cycles under full contention.
- Flush:
  - all counts, heads and tails go to 0;
  - cdb_valid = 0;
  - same-cycle pushes are discarded;
  - last_grant is unchanged.
- rdy low: no push, no pop; CDB outputs and last_grant hold; every src_full reads 1.
- Reset mid-operation overrides flush, pushes and pops.

Test Plan:
- Reset: assert rst 2 cycles -> cdb_valid = 0, every *_full = 0, and the first grant after release goes to ALU.
- Single ALU push: alu_tag = 5, alu_value = 0xDEADBEEF at edge E -> after E+1: cdb_valid = 1, tag = 5, value = 0xDEADBEEF, src = 0; after E+2: cdb_valid = 0, tag and value held.
- Three sources push together once (tags 1, 2, 3) -> CDB shows tag 1 (src 0), tag 2 (src 1), tag 3 (src 2) on three consecutive cycles, then cdb_valid = 0.
- All sources push every cycle, DEPTH = 4 -> grants rotate 0,1,2,0,…; alu_full rises once count = 4; each FIFO's pushed order is preserved across pointer wrap. Check against a scoreboard.
- Flush with 3 entries pending and a same-cycle push -> next cycle cdb_valid = 0, all FIFOs empty, no stale tag is ever broadcast. A new push after the flush broadcasts normally.
- rdy held low for 3 cycles with entries pending -> CDB outputs frozen, *_full = 1, pushes ignored. Grant order resumes exactly where it stopped when rdy returns high.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the common data bus arbiter.
//
// Handshake: a producer raises <src>_valid with <src>_tag/<src>_value for one
// cycle per result. The result is taken at the clock edge only when
// <src>_full is low at that edge. A result offered while <src>_full is high is
// dropped, so producers must hold it and retry. cdb_valid is a single-cycle
// broadcast strobe with no back-pressure: every listener must take it.
interface cdb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              alu_valid;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_value;
    logic              alu_full;

    logic              lsb_valid;
    logic [TAG_W-1:0]  lsb_tag;
    logic [DATA_W-1:0] lsb_value;
    logic              lsb_full;

    logic              rob_valid;
    logic [TAG_W-1:0]  rob_tag;
    logic [DATA_W-1:0] rob_value;
    logic              rob_full;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic [1:0]        cdb_src;

    // Producers and bus listeners
    modport master (
        output alu_valid, alu_tag, alu_value,
        output lsb_valid, lsb_tag, lsb_value,
        output rob_valid, rob_tag, rob_value,
        input  alu_full, lsb_full, rob_full,
        input  cdb_valid, cdb_tag, cdb_value, cdb_src
    );

    // The arbiter itself
    modport slave (
        input  alu_valid, alu_tag, alu_value,
        input  lsb_valid, lsb_tag, lsb_value,
        input  rob_valid, rob_tag, rob_value,
        output alu_full, lsb_full, rob_full,
        output cdb_valid, cdb_tag, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three per-source result FIFOs (ALU, LSB, ROB)
// drained one entry per cycle by a round-robin scheduler onto a registered
// broadcast bus. Source index 0 = ALU, 1 = LSB, 2 = ROB.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    cdb_arbiter_if.slave bus,
    output logic [1:0]  last_grant_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TAG_W-1:0]  tag_mem_q [3][DEPTH];
    logic [DATA_W-1:0] val_mem_q [3][DEPTH];

    logic [PTR_W-1:0]  head_q [3];
    logic [PTR_W-1:0]  head_d [3];
    logic [PTR_W-1:0]  tail_q [3];
    logic [PTR_W-1:0]  tail_d [3];
    logic [CNT_W-1:0]  cnt_q  [3];
    logic [CNT_W-1:0]  cnt_d  [3];

    logic [1:0]        last_grant_q, last_grant_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [1:0]        cdb_src_q, cdb_src_d;

    logic [2:0]        in_valid;
    logic [TAG_W-1:0]  in_tag   [3];
    logic [DATA_W-1:0] in_value [3];
    logic [2:0]        full;
    logic [2:0]        push;
    logic [2:0]        pop;
    logic              grant_vld;
    logic [1:0]        grant_idx;
    logic [1:0]        cand;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Gather the three producer ports into arrays; full has no pop look-ahead
    always_comb begin
        in_valid    = {bus.rob_valid, bus.lsb_valid, bus.alu_valid};
        in_tag[0]   = bus.alu_tag;
        in_tag[1]   = bus.lsb_tag;
        in_tag[2]   = bus.rob_tag;
        in_value[0] = bus.alu_value;
        in_value[1] = bus.lsb_value;
        in_value[2] = bus.rob_value;
        full        = '0;
        push        = '0;
        for (int s = 0; s < 3; s++) begin
            full[s] = (cnt_q[s] == FULL_CNT) | ~rdy;
            push[s] = in_valid[s] & ~full[s] & ~flush & ~rst;
        end
    end

    assign bus.alu_full  = full[0];
    assign bus.lsb_full  = full[1];
    assign bus.rob_full  = full[2];
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_value = cdb_value_q;
    assign bus.cdb_src   = cdb_src_q;
    assign last_grant_o  = last_grant_q;

    // Round-robin pick: search starts just after the last winner
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        cand      = last_grant_q;
        for (int k = 0; k < 3; k++) begin
            cand = next_src(cand);
            if (!grant_vld && cnt_q[cand] != '0) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        pop = '0;
        for (int s = 0; s < 3; s++) begin
            pop[s] = grant_vld && (grant_idx == 2'(s));
        end
    end

    // Next state: reset beats flush beats normal operation; rdy low holds all
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_tag_d    = cdb_tag_q;
        cdb_value_d  = cdb_value_q;
        cdb_src_d    = cdb_src_q;
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                head_d[s] = '0;
                tail_d[s] = '0;
                cnt_d[s]  = '0;
            end
            last_grant_d = 2'd2;
            cdb_valid_d  = 1'b0;
            cdb_tag_d    = '0;
            cdb_value_d  = '0;
            cdb_src_d    = '0;
        end else if (flush) begin
            for (int s = 0; s < 3; s++) begin
                head_d[s] = '0;
                tail_d[s] = '0;
                cnt_d[s]  = '0;
            end
            cdb_valid_d = 1'b0;
        end else if (rdy) begin
            for (int s = 0; s < 3; s++) begin
                if (push[s]) tail_d[s] = tail_q[s] + 1'b1;
                if (pop[s])  head_d[s] = head_q[s] + 1'b1;
                if (push[s] && !pop[s])      cnt_d[s] = cnt_q[s] + 1'b1;
                else if (pop[s] && !push[s]) cnt_d[s] = cnt_q[s] - 1'b1;
            end
            cdb_valid_d = grant_vld;
            if (grant_vld) begin
                cdb_tag_d    = tag_mem_q[grant_idx][head_q[grant_idx]];
                cdb_value_d  = val_mem_q[grant_idx][head_q[grant_idx]];
                cdb_src_d    = grant_idx;
                last_grant_d = grant_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        head_q       <= head_d;
        tail_q       <= tail_d;
        cnt_q        <= cnt_d;
        last_grant_q <= last_grant_d;
        cdb_valid_q  <= cdb_valid_d;
        cdb_tag_q    <= cdb_tag_d;
        cdb_value_q  <= cdb_value_d;
        cdb_src_q    <= cdb_src_d;
    end

    // FIFO storage writes; contents need no reset since counts gate reads
    always_ff @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (push[s]) begin
                tag_mem_q[s][tail_q[s]] <= in_tag[s];
                val_mem_q[s][tail_q[s]] <= in_value[s];
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed stimulus, expected broadcasts queued as
// stimulus is issued, a negedge monitor pops and compares every broadcast.
module tb_cdb_arbiter;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 4;
    localparam int EW     = 2 + TAG_W + DATA_W;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       flush;
    logic [1:0] last_grant;

    cdb_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .flush        (flush),
        .bus          (bus),
        .last_grant_o (last_grant)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    int             n_checks = 0;
    int             n_pass   = 0;
    logic [EW-1:0]  exp_q[$];
    logic [EW-1:0]  mon_exp;
    logic           edge_live = 1'b0;
    logic           saw_alu_full;
    int             sent [3];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, want);
    endtask

    function automatic logic [EW-1:0] pack(input logic [1:0] s, input logic [TAG_W-1:0] t,
                                           input logic [DATA_W-1:0] v);
        return {s, t, v};
    endfunction

    // Main process acts 2 time units after each rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int s, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d);
        case (s)
            0: begin bus.alu_valid = v; bus.alu_tag = t; bus.alu_value = d; end
            1: begin bus.lsb_valid = v; bus.lsb_tag = t; bus.lsb_value = d; end
            default: begin bus.rob_valid = v; bus.rob_tag = t; bus.rob_value = d; end
        endcase
    endtask

    task automatic idle_all();
        for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, '0);
    endtask

    function automatic logic full_of(input int s);
        case (s)
            0:       return bus.alu_full;
            1:       return bus.lsb_full;
            default: return bus.rob_full;
        endcase
    endfunction

    task automatic check_fulls(input string name, input logic want);
        check({name, "_alu_full"}, bus.alu_full, want);
        check({name, "_lsb_full"}, bus.lsb_full, want);
        check({name, "_rob_full"}, bus.rob_full, want);
    endtask

    // Wait (bounded) for every queued broadcast, then require an idle bus
    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        check({name, "_pending_left"}, exp_q.size(), 0);
        exp_q.delete();
        check({name, "_idle_after"}, bus.cdb_valid, 1'b0);
    endtask

    // An edge can only produce a fresh broadcast when neither rst nor rdy-low held it
    always @(posedge clk) edge_live <= rdy && !rst;

    // Monitor: every fresh broadcast must match the head of the expected queue
    always @(negedge clk) begin
        if (edge_live && bus.cdb_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_broadcast: got src %0d tag %0h value %0h, required no broadcast",
                         bus.cdb_src, bus.cdb_tag, bus.cdb_value);
            end else begin
                mon_exp = exp_q.pop_front();
                check("cdb_broadcast", 64'({bus.cdb_src, bus.cdb_tag, bus.cdb_value}), 64'(mon_exp));
            end
        end
    end

    initial begin
        rst   = 1'b1;
        rdy   = 1'b1;
        flush = 1'b0;
        idle_all();

        // Reset held two cycles
        tick();
        tick();
        check("reset_cdb_valid", bus.cdb_valid, 1'b0);
        check("reset_cdb_tag",   bus.cdb_tag,   '0);
        check("reset_cdb_value", bus.cdb_value, '0);
        check("reset_cdb_src",   bus.cdb_src,   '0);
        check_fulls("reset", 1'b0);
        rst = 1'b0;

        // Three sources at once right after reset: ALU, LSB, ROB in order
        exp_q.push_back(pack(2'd0, 4'd1, 32'h1111_1111));
        exp_q.push_back(pack(2'd1, 4'd2, 32'h2222_2222));
        exp_q.push_back(pack(2'd2, 4'd3, 32'h3333_3333));
        drive(0, 1'b1, 4'd1, 32'h1111_1111);
        drive(1, 1'b1, 4'd2, 32'h2222_2222);
        drive(2, 1'b1, 4'd3, 32'h3333_3333);
        tick();
        idle_all();
        drain("three_src");

        // Single ALU push: one-cycle broadcast, then tag/value held
        exp_q.push_back(pack(2'd0, 4'd5, 32'hDEAD_BEEF));
        drive(0, 1'b1, 4'd5, 32'hDEAD_BEEF);
        tick();
        idle_all();
        check("single_mid_valid", bus.cdb_valid, 1'b0);
        tick();
        check("single_valid", bus.cdb_valid, 1'b1);
        check("single_tag",   bus.cdb_tag,   4'd5);
        check("single_value", bus.cdb_value, 32'hDEAD_BEEF);
        check("single_src",   bus.cdb_src,   2'd0);
        tick();
        check("single_after_valid", bus.cdb_valid, 1'b0);
        check("single_held_tag",    bus.cdb_tag,   4'd5);
        check("single_held_value",  bus.cdb_value, 32'hDEAD_BEEF);
        drain("single");

        // Full contention: six entries per source, honouring full; last winner
        // was ALU so the rotation runs LSB, ROB, ALU with per-source FIFO order
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(pack(2'd1, 4'(i + 6),  32'hB000_0000 + 32'(i)));
            exp_q.push_back(pack(2'd2, 4'(i + 10), 32'hC000_0000 + 32'(i)));
            exp_q.push_back(pack(2'd0, 4'(i),      32'hA000_0000 + 32'(i)));
        end
        sent = '{0, 0, 0};
        saw_alu_full = 1'b0;
        for (int c = 0; c < 60 && (sent[0] < 6 || sent[1] < 6 || sent[2] < 6); c++) begin
            if (bus.alu_full) saw_alu_full = 1'b1;
            for (int s = 0; s < 3; s++) begin
                if (sent[s] < 6 && !full_of(s)) begin
                    case (s)
                        0:       drive(s, 1'b1, 4'(sent[s]),      32'hA000_0000 + 32'(sent[s]));
                        1:       drive(s, 1'b1, 4'(sent[s] + 6),  32'hB000_0000 + 32'(sent[s]));
                        default: drive(s, 1'b1, 4'(sent[s] + 10), 32'hC000_0000 + 32'(sent[s]));
                    endcase
                    sent[s]++;
                end else begin
                    drive(s, 1'b0, '0, '0);
                end
            end
            tick();
        end
        idle_all();
        check("contention_alu_full_seen", saw_alu_full, 1'b1);
        drain("contention");

        // Flush with three entries pending and a same-cycle push
        drive(0, 1'b1, 4'd7, 32'h7777_7777);
        drive(1, 1'b1, 4'd8, 32'h8888_8888);
        drive(2, 1'b1, 4'd9, 32'h9999_9999);
        tick();
        idle_all();
        flush = 1'b1;
        drive(0, 1'b1, 4'd4, 32'h4444_4444);
        tick();
        flush = 1'b0;
        idle_all();
        check("flush_cdb_valid", bus.cdb_valid, 1'b0);
        check_fulls("flush", 1'b0);
        repeat (4) tick();
        check("flush_quiet_valid", bus.cdb_valid, 1'b0);
        exp_q.push_back(pack(2'd0, 4'd6, 32'h6666_6666));
        drive(0, 1'b1, 4'd6, 32'h6666_6666);
        tick();
        idle_all();
        drain("post_flush");

        // rdy low for three cycles with entries pending; last winner was ALU
        exp_q.push_back(pack(2'd1, 4'd2, 32'h2020_2020));
        exp_q.push_back(pack(2'd2, 4'd3, 32'h3030_3030));
        exp_q.push_back(pack(2'd0, 4'd1, 32'h1010_1010));
        drive(0, 1'b1, 4'd1, 32'h1010_1010);
        drive(1, 1'b1, 4'd2, 32'h2020_2020);
        drive(2, 1'b1, 4'd3, 32'h3030_3030);
        tick();
        idle_all();
        tick();
        rdy = 1'b0;
        drive(0, 1'b1, 4'd15, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", bus.cdb_valid, 1'b1);
            check("stall_tag",   bus.cdb_tag,   4'd2);
            check("stall_src",   bus.cdb_src,   2'd1);
            check_fulls("stall", 1'b1);
        end
        rdy = 1'b1;
        idle_all();
        drain("stall_resume");

        // Reset mid-operation discards pending entries and restores ALU priority
        drive(0, 1'b1, 4'd10, 32'h0A0A_0A0A);
        drive(1, 1'b1, 4'd11, 32'h0B0B_0B0B);
        drive(2, 1'b1, 4'd12, 32'h0C0C_0C0C);
        tick();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_cdb_valid", bus.cdb_valid, 1'b0);
        check_fulls("midrst", 1'b0);
        repeat (3) tick();
        exp_q.push_back(pack(2'd0, 4'd13, 32'hD0D0_D0D0));
        exp_q.push_back(pack(2'd1, 4'd14, 32'hE0E0_E0E0));
        drive(0, 1'b1, 4'd13, 32'hD0D0_D0D0);
        drive(1, 1'b1, 4'd14, 32'hE0E0_E0E0);
        tick();
        idle_all();
        drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
